// File: rtl/event_frame_unpacker_if.sv
// Frame-word input, HPTDC FIFO write port and per-event status of the event frame unpacker.
// The unpacker takes the slave modport; the link/bench side takes the master modport.
interface event_frame_unpacker_if;
    logic [63:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] data_out;
    logic        write_enable;
    logic        full;
    logic [3:0]  trigger_type;
    logic [23:0] lv1;
    logic [11:0] bx;
    logic [11:0] fec_id;
    logic [3:0]  fov;
    logic [12:0] word_count;
    logic        event_done;
    logic        length_error;
    logic        overflow_error;
    logic        header_error;

    modport slave (
        input  data_in, data_valid, full,
        output data_ready, data_out, write_enable, trigger_type, lv1, bx, fec_id, fov,
               word_count, event_done, length_error, overflow_error, header_error
    );

    modport master (
        output data_in, data_valid, full,
        input  data_ready, data_out, write_enable, trigger_type, lv1, bx, fec_id, fov,
               word_count, event_done, length_error, overflow_error, header_error
    );
endinterface

// File: rtl/event_frame_unpacker.sv
// Receive side of the 64-bit event frame stream: latches header fields, splits payload words
// into two 32-bit HPTDC writes with FIFO backpressure, and checks the trailer length.
module event_frame_unpacker #(
    parameter int MAX_PAYLOAD = 128,
    parameter int LEN_W       = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    event_frame_unpacker_if.slave  bus
);
    localparam int PC_W = $clog2(MAX_PAYLOAD + 1);

    typedef enum logic [2:0] {
        S_HEADER,
        S_BODY,
        S_WR_HI,
        S_WR_LO,
        S_DRAIN
    } state_t;

    state_t            r_state;
    logic [12:0]       r_count;
    logic [PC_W-1:0]   r_payloadCount;
    logic [63:0]       r_word;
    logic [31:0]       r_dataOut;
    logic              r_writeEnable;
    logic [3:0]        r_triggerType;
    logic [23:0]       r_lv1;
    logic [11:0]       r_bx;
    logic [11:0]       r_fecId;
    logic [3:0]        r_fov;
    logic [12:0]       r_wordCount;
    logic              r_eventDone;
    logic              r_lengthError;
    logic              r_overflowError;
    logic              r_headerError;

    logic              w_ready;
    logic              w_accept;
    logic              w_isHeader;
    logic              w_isTrailer;
    logic [12:0]       w_countInc;
    logic              w_lengthMismatch;
    logic              w_latchHeader;

    assign w_ready     = (r_state == S_HEADER) || (r_state == S_BODY) || (r_state == S_DRAIN);
    assign w_accept    = bus.data_valid && w_ready;
    assign w_isHeader  = (bus.data_in[63:60] == 4'b1010);
    assign w_isTrailer = (bus.data_in[63:60] == 4'b1011);
    assign w_countInc  = (r_count == 13'h1FFF) ? r_count : r_count + 13'd1;
    assign w_lengthMismatch = (bus.data_in[32 +: LEN_W] != {{(LEN_W-13){1'b0}}, w_countInc});
    assign w_latchHeader = w_accept && w_isHeader && ((r_state == S_HEADER) || (r_state == S_BODY));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_triggerType <= '0;
            r_lv1         <= '0;
            r_bx          <= '0;
            r_fecId       <= '0;
            r_fov         <= '0;
        end else if (w_latchHeader) begin
            r_triggerType <= bus.data_in[59:56];
            r_lv1         <= bus.data_in[55:32];
            r_bx          <= bus.data_in[31:20];
            r_fecId       <= bus.data_in[19:8];
            r_fov         <= bus.data_in[7:4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_HEADER;
            r_count         <= '0;
            r_payloadCount  <= '0;
            r_word          <= '0;
            r_dataOut       <= '0;
            r_writeEnable   <= 1'b0;
            r_wordCount     <= '0;
            r_eventDone     <= 1'b0;
            r_lengthError   <= 1'b0;
            r_overflowError <= 1'b0;
            r_headerError   <= 1'b0;
        end else begin
            r_writeEnable   <= 1'b0;
            r_eventDone     <= 1'b0;
            r_lengthError   <= 1'b0;
            r_overflowError <= 1'b0;
            r_headerError   <= 1'b0;
            unique case (r_state)
                S_HEADER: begin
                    if (w_accept) begin
                        if (w_isHeader) begin
                            r_count        <= 13'd1;
                            r_payloadCount <= '0;
                            r_state        <= S_BODY;
                        end else begin
                            r_headerError  <= 1'b1;
                        end
                    end
                end
                S_BODY: begin
                    if (w_accept) begin
                        if (w_isTrailer) begin
                            r_count       <= w_countInc;
                            r_wordCount   <= w_countInc;
                            r_eventDone   <= 1'b1;
                            r_lengthError <= w_lengthMismatch;
                            r_state       <= S_HEADER;
                        end else if (w_isHeader) begin
                            // Missing trailer: close the old event and start the new one in place
                            r_wordCount    <= r_count;
                            r_eventDone    <= 1'b1;
                            r_lengthError  <= 1'b1;
                            r_count        <= 13'd1;
                            r_payloadCount <= '0;
                        end else if (r_payloadCount == PC_W'(MAX_PAYLOAD)) begin
                            r_overflowError <= 1'b1;
                            r_count         <= w_countInc;
                            r_state         <= S_DRAIN;
                        end else begin
                            r_word          <= bus.data_in;
                            r_count         <= w_countInc;
                            r_payloadCount  <= r_payloadCount + 1'b1;
                            r_state         <= S_WR_HI;
                        end
                    end
                end
                S_WR_HI: begin
                    if (!bus.full) begin
                        r_writeEnable <= |r_word[63:32];
                        if (|r_word[63:32]) r_dataOut <= r_word[63:32];
                        r_state <= S_WR_LO;
                    end
                end
                S_WR_LO: begin
                    if (!bus.full) begin
                        r_writeEnable <= |r_word[31:0];
                        if (|r_word[31:0]) r_dataOut <= r_word[31:0];
                        r_state <= S_BODY;
                    end
                end
                S_DRAIN: begin
                    if (w_accept) begin
                        r_count <= w_countInc;
                        if (w_isTrailer) begin
                            r_wordCount   <= w_countInc;
                            r_eventDone   <= 1'b1;
                            r_lengthError <= 1'b1;
                            r_state       <= S_HEADER;
                        end
                    end
                end
                default: r_state <= S_HEADER;
            endcase
        end
    end

    assign bus.data_ready     = w_ready;
    assign bus.data_out       = r_dataOut;
    assign bus.write_enable   = r_writeEnable;
    assign bus.trigger_type   = r_triggerType;
    assign bus.lv1            = r_lv1;
    assign bus.bx             = r_bx;
    assign bus.fec_id         = r_fecId;
    assign bus.fov            = r_fov;
    assign bus.word_count     = r_wordCount;
    assign bus.event_done     = r_eventDone;
    assign bus.length_error   = r_lengthError;
    assign bus.overflow_error = r_overflowError;
    assign bus.header_error   = r_headerError;
endmodule

// File: tb/tb_event_frame_unpacker.sv
// Self-checking bench for event_frame_unpacker: directed frames plus randomized frames and FIFO
// backpressure, compared against a word-by-word behavioural model of the frame rules.
module tb_event_frame_unpacker;
    localparam int MAX = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    event_frame_unpacker_if bus ();

    event_frame_unpacker #(.MAX_PAYLOAD(MAX), .LEN_W(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic randFull = 1'b0;

    logic [31:0] expWrites[$];
    logic [31:0] obsWrites[$];
    logic [13:0] expEvents[$];
    logic [13:0] obsEvents[$];
    int expOvf = 0, obsOvf = 0, expHdr = 0, obsHdr = 0, pulseClash = 0;

    int          mMode = 0;
    logic [12:0] mCount = '0;
    int          mPayloads = 0;
    logic [3:0]  mTrig = '0, mFov = '0;
    logic [23:0] mLv1 = '0;
    logic [11:0] mBx = '0, mFec = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.write_enable) obsWrites.push_back(bus.data_out);
            if (bus.event_done) obsEvents.push_back({bus.length_error, bus.word_count});
            if (bus.overflow_error) obsOvf++;
            if (bus.header_error) obsHdr++;
            if (int'(bus.event_done) + int'(bus.overflow_error) + int'(bus.header_error) > 1) pulseClash++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (randFull) bus.full = ($urandom_range(0, 2) == 0);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] satInc(input logic [12:0] c);
        return (c == 13'h1FFF) ? c : c + 13'd1;
    endfunction

    task automatic modelLatch(input logic [63:0] w);
        mTrig = w[59:56]; mLv1 = w[55:32]; mBx = w[31:20]; mFec = w[19:8]; mFov = w[7:4];
        mCount = 13'd1;
        mPayloads = 0;
    endtask

    // Frame rules applied one accepted word at a time: 0 = waiting for header, 1 = in event, 2 = discarding
    task automatic modelWord(input logic [63:0] w);
        if (mMode == 0) begin
            if (w[63:60] == 4'hA) begin
                modelLatch(w);
                mMode = 1;
            end else expHdr++;
        end else if (mMode == 1) begin
            if (w[63:60] == 4'hB) begin
                mCount = satInc(mCount);
                expEvents.push_back({w[55:32] != {11'b0, mCount}, mCount});
                mMode = 0;
            end else if (w[63:60] == 4'hA) begin
                expEvents.push_back({1'b1, mCount});
                modelLatch(w);
            end else if (mPayloads == MAX) begin
                expOvf++;
                mCount = satInc(mCount);
                mMode = 2;
            end else begin
                mPayloads++;
                mCount = satInc(mCount);
                if (w[63:32] != 0) expWrites.push_back(w[63:32]);
                if (w[31:0] != 0) expWrites.push_back(w[31:0]);
            end
        end else begin
            mCount = satInc(mCount);
            if (w[63:60] == 4'hB) begin
                expEvents.push_back({1'b1, mCount});
                mMode = 0;
            end
        end
    endtask

    task automatic modelReset();
        mMode = 0; mCount = '0; mPayloads = 0;
        mTrig = '0; mLv1 = '0; mBx = '0; mFec = '0; mFov = '0;
        expWrites.delete(); obsWrites.delete(); expEvents.delete(); obsEvents.delete();
        expOvf = 0; obsOvf = 0; expHdr = 0; obsHdr = 0;
    endtask

    // Called on a falling edge; returns on the falling edge just after the word transferred
    task automatic applyStimulus(input logic [63:0] w, input int gap);
        int n = 0;
        modelWord(w);
        bus.data_in = w;
        bus.data_valid = 1'b1;
        while (!bus.data_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) checkOutput("ready_timeout", 64'(n), 64'd0);
        @(negedge clk);
        bus.data_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic compareRun(input string tag);
        repeat (6) @(negedge clk);
        checkOutput({tag, ".nwrites"}, 64'(obsWrites.size()), 64'(expWrites.size()));
        for (int i = 0; i < expWrites.size() && i < obsWrites.size(); i++)
            checkOutput($sformatf("%s.write%0d", tag, i), 64'(obsWrites[i]), 64'(expWrites[i]));
        checkOutput({tag, ".nevents"}, 64'(obsEvents.size()), 64'(expEvents.size()));
        for (int i = 0; i < expEvents.size() && i < obsEvents.size(); i++)
            checkOutput($sformatf("%s.event%0d", tag, i), 64'(obsEvents[i]), 64'(expEvents[i]));
        checkOutput({tag, ".overflow"}, 64'(obsOvf), 64'(expOvf));
        checkOutput({tag, ".header_error"}, 64'(obsHdr), 64'(expHdr));
        checkOutput({tag, ".fields"},
                    {8'h0, bus.trigger_type, bus.lv1, bus.bx, bus.fec_id, bus.fov},
                    {8'h0, mTrig, mLv1, mBx, mFec, mFov});
        expWrites.delete(); obsWrites.delete(); expEvents.delete(); obsEvents.delete();
        expOvf = 0; obsOvf = 0; expHdr = 0; obsHdr = 0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".data_out"}, 64'(bus.data_out), 64'd0);
        checkOutput({tag, ".pulses"},
                    {60'd0, bus.write_enable, bus.event_done, bus.overflow_error, bus.header_error}, 64'd0);
        checkOutput({tag, ".fields"},
                    {8'h0, bus.trigger_type, bus.lv1, bus.bx, bus.fec_id, bus.fov}, 64'd0);
        checkOutput({tag, ".word_count"}, 64'(bus.word_count), 64'd0);
        checkOutput({tag, ".data_ready"}, 64'(bus.data_ready), 64'd1);
    endtask

    function automatic logic [63:0] randPayload();
        logic [31:0] hi = $urandom;
        logic [31:0] lo = $urandom;
        int sel = $urandom_range(0, 3);
        if (sel == 0) hi = '0;
        else if (sel == 1) lo = '0;
        if (hi[31:28] == 4'hA || hi[31:28] == 4'hB) hi[31:28] = 4'h4;
        return {hi, lo};
    endfunction

    function automatic logic [63:0] randHeader();
        logic [59:0] body = {$urandom, $urandom};
        return {4'hA, body};
    endfunction

    initial begin
        logic [63:0] hdrA = 64'hA2000002_01E00A24;
        logic [63:0] trl3 = 64'hB0000003_00000000;
        bus.data_in = '0;
        bus.data_valid = 1'b0;
        bus.full = 1'b0;
        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic frame
        applyStimulus(hdrA, 0);
        applyStimulus(64'h40000005_50000007, 0);
        applyStimulus(trl3, 0);
        compareRun("basic");
        checkOutput("basic.fields_direct",
                    {8'h0, bus.trigger_type, bus.lv1, bus.bx, bus.fec_id, bus.fov},
                    {8'h0, 4'd2, 24'd2, 12'd30, 12'd10, 4'd2});

        // FIFO full held for four cycles after the payload accept
        applyStimulus(hdrA, 0);
        bus.full = 1'b1;
        applyStimulus(64'h40000005_50000007, 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("full.hold%0d", i), {62'd0, bus.write_enable, bus.data_ready}, 64'd0);
            @(negedge clk);
        end
        bus.full = 1'b0;
        applyStimulus(trl3, 0);
        compareRun("full");

        // Padding upper half, then bad trailer length
        applyStimulus(hdrA, 1);
        applyStimulus(64'h00000000_60001234, 1);
        applyStimulus(trl3, 0);
        compareRun("padding");
        applyStimulus(hdrA, 0);
        applyStimulus(64'h40000005_50000007, 0);
        applyStimulus(64'hB0000005_00000000, 0);
        compareRun("badlen");

        // Overflow: 129 payload words
        applyStimulus(hdrA, 0);
        for (int i = 0; i < MAX + 1; i++)
            applyStimulus({32'h40000000 | 32'(i + 1), 32'h50000000 | 32'(i + 1)}, 0);
        applyStimulus(64'hB0000083_00000000, 0);
        compareRun("overflow");

        // Stray word while idle, then a missing trailer
        applyStimulus(64'h40000000_00000001, 0);
        applyStimulus(hdrA, 0);
        applyStimulus(64'h40000011_00000022, 0);
        applyStimulus(randHeader(), 0);
        applyStimulus(64'hB0000002_00000000, 0);
        compareRun("idle_missing_trailer");

        // Randomized frames under random backpressure
        randFull = 1'b1;
        for (int f = 0; f < 25; f++) begin
            int np = $urandom_range(0, 6);
            if ($urandom_range(0, 4) == 0) applyStimulus({4'h3, 60'($urandom)}, 0);
            applyStimulus(randHeader(), $urandom_range(0, 1));
            for (int p = 0; p < np; p++) applyStimulus(randPayload(), $urandom_range(0, 2));
            if ($urandom_range(0, 5) != 0 || f == 24) begin
                logic [23:0] len = ($urandom_range(0, 3) == 0) ? 24'($urandom_range(0, 9)) : 24'(np + 2);
                applyStimulus({8'hB0, len, 32'($urandom)}, $urandom_range(0, 2));
            end
        end
        randFull = 1'b0;
        bus.full = 1'b0;
        compareRun("random");

        // Reset in the middle of a payload word
        applyStimulus(hdrA, 0);
        applyStimulus(64'h40000099_500000AA, 0);
        rst = 1'b1;
        @(negedge clk);
        checkResetState("midreset");
        rst = 1'b0;
        modelReset();
        @(negedge clk);
        applyStimulus(hdrA, 0);
        applyStimulus(64'h40000005_50000007, 0);
        applyStimulus(trl3, 0);
        compareRun("after_reset");

        checkOutput("pulse_exclusive", 64'(pulseClash), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
